// File: rtl/lamp_dwell_timer.sv
// Pacing stage for the cyclic lamp sequencer: holds each lamp phase for a
// programmable number of prescaled ticks, then pulses `step` and waits for the new code.
module lamp_dwell_timer #(
    parameter int TICK_DIV      = 2,
    parameter int CNT_W         = 8,
    parameter int GREEN_TICKS   = 20,
    parameter int YELLOW_TICKS  = 4,
    parameter int RED_TICKS     = 16,
    parameter int PED_MIN_GREEN = 5,
    parameter int ACK_TIMEOUT   = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       light,
    input  logic             ped_req,
    input  logic             hold,
    output logic             step,
    output logic [CNT_W-1:0] phase_remaining,
    output logic             ped_pending,
    output logic             fault,
    output logic [2:0]       state_dbg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [2:0]       L_RED      = 3'b100;
    localparam logic [2:0]       L_GREEN    = 3'b010;
    localparam logic [2:0]       L_YELLOW   = 3'b001;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0]    ACK_LAST   = AW'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GREEN_CNT  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YELLOW_CNT = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] RED_CNT    = CNT_W'(RED_TICKS);
    localparam logic [CNT_W:0]   PED_MIN    = (CNT_W + 1)'(PED_MIN_GREEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_STEP,
        S_WAIT_ACK,
        S_FAULT
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [AW-1:0]   ack_cnt;
    logic [2:0]      light_ld;
    logic [2:0]      exp_code;
    logic [2:0]      next_code;
    logic [CNT_W:0]  elapsed;
    logic            tick;
    logic            count_tick;
    logic            ped_exit;
    logic            end_phase;
    logic            light_bad;
    logic            leave_green;

    assign state_dbg = state;

    // Elapsed green ticks including the tick being evaluated now.
    assign elapsed     = {1'b0, GREEN_CNT} - {1'b0, phase_remaining} + {{CNT_W{1'b0}}, 1'b1};
    assign tick        = (presc == PRESC_LAST);
    assign count_tick  = tick && !hold;
    assign light_bad   = (light != light_ld);
    assign ped_exit    = (light_ld == L_GREEN) && ped_pending && (elapsed >= PED_MIN);
    assign end_phase   = count_tick && ((phase_remaining == CNT_W'(1)) || ped_exit);
    assign leave_green = (light_ld == L_GREEN) &&
                         (((state == S_COUNT) && !light_bad && end_phase) || (state == S_STEP));

    always_comb begin
        next_code = L_GREEN;
        case (light_ld)
            L_GREEN:  next_code = L_YELLOW;
            L_YELLOW: next_code = L_RED;
            default:  next_code = L_GREEN;
        endcase
    end

    // Advance handshake: `step` is a single-cycle request; the sequencer acknowledges
    // by presenting the successor code on `light` within ACK_TIMEOUT cycles of it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            step            <= 1'b0;
            fault           <= 1'b0;
            ped_pending     <= 1'b0;
            phase_remaining <= '0;
            presc           <= '0;
            ack_cnt         <= '0;
            light_ld        <= '0;
            exp_code        <= '0;
        end else begin
            step <= 1'b0;
            if (leave_green) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    presc    <= '0;
                    light_ld <= light;
                    state    <= S_COUNT;
                    case (light)
                        L_GREEN:  phase_remaining <= GREEN_CNT;
                        L_YELLOW: phase_remaining <= YELLOW_CNT;
                        L_RED:    phase_remaining <= RED_CNT;
                        default: begin
                            phase_remaining <= '0;
                            fault           <= 1'b1;
                            state           <= S_FAULT;
                        end
                    endcase
                end
                S_COUNT: begin
                    if (tick) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                    if (light_bad) begin
                        phase_remaining <= '0;
                        fault           <= 1'b1;
                        state           <= S_FAULT;
                    end else if (end_phase) begin
                        phase_remaining <= '0;
                        step            <= 1'b1;
                        state           <= S_STEP;
                    end else if (count_tick) begin
                        phase_remaining <= phase_remaining - CNT_W'(1);
                    end
                end
                S_STEP: begin
                    exp_code <= next_code;
                    ack_cnt  <= '0;
                    state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (light == exp_code) begin
                        state <= S_LOAD;
                    end else if (ack_cnt == ACK_LAST) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                S_FAULT: begin
                    fault           <= 1'b1;
                    phase_remaining <= '0;
                end
                default: begin
                    fault <= 1'b1;
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule
